// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller.
// The optional PAUSE state exists only when PONG_PAUSE_EN is defined.
package pong_pkg;

    localparam int LIVES_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
`ifdef PONG_PAUSE_EN
        , ST_PAUSE = 3'd5
`endif
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    // Lives never wrap below zero.
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/debounce.sv
// Rising-edge detector for level control inputs (start, pause).
module debounce (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);
    logic prev_q;

    // Remember last sampled level; a rise needs a 0 seen before the 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) prev_q <= 1'b0;
        else          prev_q <= i_sig;
    end

    assign o_rise = i_sig & ~prev_q;
endmodule

// File: rtl/frame_timer.sv
// Counts animation strobes while enabled; o_done fires on the TC-th strobe.
module frame_timer #(
    parameter int TC = 60
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_stb,
    output logic o_done
);
    localparam int CW = (TC < 2) ? 1 : $clog2(TC);
    localparam logic [CW-1:0] LAST = CW'(TC - 1);

    logic [CW-1:0] cnt_q;

    assign o_done = i_en & i_stb & (cnt_q == LAST);

    // Strobe counter; clear wins so every state entry starts from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr)  cnt_q <= '0;
        else if (i_en && i_stb) cnt_q <= o_done ? '0 : cnt_q + CW'(1);
    end
endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve / rally / point / game-over sequencing.
// Optional PONG_PAUSE_EN adds i_pause and a PAUSE state entered from PLAY.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES        = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ani_stb,
    input  logic [1:0]         i_mode,
    input  logic               i_start,
    input  logic               i_miss_l,
    input  logic               i_miss_r,
`ifdef PONG_PAUSE_EN
    input  logic               i_pause,
`endif
    output logic               o_animate,
    output logic               o_ball_rst,
    output logic               o_serve_dir,
    output logic [LIVES_W-1:0] o_lives1,
    output logic [LIVES_W-1:0] o_lives2,
    output logic               o_endgame,
    output logic [1:0]         o_winner,
    output logic [2:0]         o_state
);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_e             state_q, state_d;
    logic [LIVES_W-1:0] lives1_q, lives1_d, lives2_q, lives2_d;
    logic               dir_q, dir_d;
    logic [1:0]         win_q, win_d;
    logic               brst_q, brst_d;
    logic               start_rise, serve_done, point_done, tmr_clr;
    logic               new_match;

    debounce u_start_edge (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(i_start), .o_rise(start_rise)
    );

`ifdef PONG_PAUSE_EN
    logic pause_rise;
    debounce u_pause_edge (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sig(i_pause), .o_rise(pause_rise)
    );
`endif

    // Timers restart whenever the state changes.
    assign tmr_clr = (state_d != state_q);

    frame_timer #(.TC(SERVE_FRAMES)) u_serve_tmr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(tmr_clr),
        .i_en(state_q == ST_SERVE), .i_stb(i_ani_stb), .o_done(serve_done)
    );

    frame_timer #(.TC(POINT_FRAMES)) u_point_tmr (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clr(tmr_clr),
        .i_en(state_q == ST_POINT), .i_stb(i_ani_stb), .o_done(point_done)
    );

    // Next-state logic; mode 0 overrides everything and parks the match in IDLE.
    always_comb begin
        state_d   = state_q;
        lives1_d  = lives1_q;
        lives2_d  = lives2_q;
        dir_d     = dir_q;
        win_d     = win_q;
        brst_d    = 1'b0;
        new_match = 1'b0;
        if (i_mode == 2'd0) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                brst_d  = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE:  new_match = i_start;
                ST_SERVE: if (serve_done) state_d = ST_PLAY;
                ST_PLAY: begin
                    // Left miss wins a tie; later misses land in POINT and are dropped.
                    if (i_miss_l) begin
                        lives2_d = lives_dec(lives2_q);
                        dir_d    = SERVE_LEFT;
                        state_d  = ST_POINT;
                    end else if (i_miss_r) begin
                        lives1_d = lives_dec(lives1_q);
                        dir_d    = SERVE_RIGHT;
                        state_d  = ST_POINT;
                    end
`ifdef PONG_PAUSE_EN
                    else if (pause_rise) state_d = ST_PAUSE;
`endif
                end
                ST_POINT: begin
                    if (lives1_q == '0 || lives2_q == '0) begin
                        state_d = ST_OVER;
                        win_d   = (lives2_q == '0) ? WIN_P1 : WIN_P2;
                    end else if (point_done) begin
                        state_d = ST_SERVE;
                        brst_d  = 1'b1;
                    end
                end
                ST_OVER:  new_match = start_rise;
`ifdef PONG_PAUSE_EN
                ST_PAUSE: if (pause_rise) state_d = ST_PLAY;
`endif
                default:  state_d = ST_IDLE;
            endcase
            if (new_match) begin
                lives1_d = LIVES_INIT;
                lives2_d = LIVES_INIT;
                win_d    = WIN_NONE;
                brst_d   = 1'b1;
                state_d  = ST_SERVE;
            end
        end
    end

    // Match registers; reset drops any pending point or re-centre pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            lives1_q <= LIVES_INIT;
            lives2_q <= LIVES_INIT;
            dir_q    <= SERVE_LEFT;
            win_q    <= WIN_NONE;
            brst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives1_q <= lives1_d;
            lives2_q <= lives2_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            brst_q   <= brst_d;
        end
    end

    assign o_animate   = (state_q == ST_PLAY);
    assign o_ball_rst  = brst_q;
    assign o_serve_dir = dir_q;
    assign o_lives1    = lives1_q;
    assign o_lives2    = lives2_q;
    assign o_endgame   = (state_q == ST_OVER);
    assign o_winner    = win_q;
    assign o_state     = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed scenarios, then random play against a rule model.
module tb_pong_match_ctrl;
    import pong_pkg::*;

    localparam int LV = 3;
    localparam int SF = 3;
    localparam int PF = 2;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    // model phases
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4, P_PAUSE = 5;

    logic       clk = 1'b0;
    logic       rst_n, stb, start, miss_l, miss_r, pause;
    logic [1:0] mode;
    logic       o_animate, o_ball_rst, o_serve_dir, o_endgame;
    logic [7:0] o_lives1, o_lives2;
    logic [1:0] o_winner;
    logic [2:0] o_state;

    int errors = 0;
    int checks = 0;

    // model state
    int m_ph, m_left, m_l1, m_l2, m_win;
    bit m_dir, m_brst, m_sprev, m_pprev;

    // current level inputs used by the helper steps
    bit cur_start, cur_pause;
    logic [1:0] cur_mode;

    always #5 clk = ~clk;

    pong_match_ctrl #(.LIVES(LV), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(stb), .i_mode(mode),
        .i_start(start), .i_miss_l(miss_l), .i_miss_r(miss_r),
`ifdef PONG_PAUSE_EN
        .i_pause(pause),
`endif
        .o_animate(o_animate), .o_ball_rst(o_ball_rst), .o_serve_dir(o_serve_dir),
        .o_lives1(o_lives1), .o_lives2(o_lives2), .o_endgame(o_endgame),
        .o_winner(o_winner), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_state(input int ph);
        case (ph)
            P_SERVE: return ST_SERVE;
            P_PLAY:  return ST_PLAY;
            P_POINT: return ST_POINT;
            P_OVER:  return ST_OVER;
`ifdef PONG_PAUSE_EN
            P_PAUSE: return ST_PAUSE;
`endif
            default: return ST_IDLE;
        endcase
    endfunction

    task automatic new_match();
        m_l1 = LV; m_l2 = LV; m_win = 0; m_brst = 1'b1; m_ph = P_SERVE; m_left = SF;
    endtask

    // Rule model: what one clock edge does to the match given these inputs.
    task automatic model_edge(input bit r, input bit s, input bit st, input bit ml,
                              input bit mr, input bit p, input logic [1:0] md);
        bit srise, prise;
        srise = s && !m_sprev;
        prise = p && !m_pprev && PAUSE_ON;
        if (!r) begin
            m_ph = P_IDLE; m_l1 = LV; m_l2 = LV; m_dir = 0; m_win = 0;
            m_brst = 0; m_left = 0; m_sprev = 0; m_pprev = 0;
            return;
        end
        m_brst = 1'b0;
        if (md == 2'd0) begin
            if (m_ph != P_IDLE) begin m_ph = P_IDLE; m_brst = 1'b1; end
        end else begin
            case (m_ph)
                P_IDLE:  if (s) new_match();
                P_SERVE: if (st) begin m_left--; if (m_left == 0) m_ph = P_PLAY; end
                P_PLAY: begin
                    if (ml) begin
                        m_l2 = (m_l2 > 0) ? m_l2 - 1 : 0; m_dir = 0; m_ph = P_POINT; m_left = PF;
                    end else if (mr) begin
                        m_l1 = (m_l1 > 0) ? m_l1 - 1 : 0; m_dir = 1; m_ph = P_POINT; m_left = PF;
                    end else if (prise) m_ph = P_PAUSE;
                end
                P_POINT: begin
                    if (m_l1 == 0 || m_l2 == 0) begin
                        m_ph = P_OVER; m_win = (m_l2 == 0) ? 1 : 2;
                    end else if (st) begin
                        m_left--;
                        if (m_left == 0) begin m_brst = 1'b1; m_ph = P_SERVE; m_left = SF; end
                    end
                end
                P_OVER:  if (srise) new_match();
                P_PAUSE: if (prise) m_ph = P_PLAY;
                default: m_ph = P_IDLE;
            endcase
        end
        m_sprev = s;
        m_pprev = p;
    endtask

    task automatic check_all();
        chk("state",    8'(o_state),     8'(exp_state(m_ph)));
        chk("animate",  8'(o_animate),   8'(m_ph == P_PLAY));
        chk("ball_rst", 8'(o_ball_rst),  8'(m_brst));
        chk("dir",      8'(o_serve_dir), 8'(m_dir));
        chk("lives1",   o_lives1,        8'(m_l1));
        chk("lives2",   o_lives2,        8'(m_l2));
        chk("endgame",  8'(o_endgame),   8'(m_ph == P_OVER));
        chk("winner",   8'(o_winner),    8'(m_win));
    endtask

    task automatic step(input bit r, input bit s, input bit st, input bit ml,
                        input bit mr, input bit p, input logic [1:0] md);
        @(negedge clk);
        rst_n = r; start = s; stb = st; miss_l = ml; miss_r = mr; pause = p; mode = md;
        model_edge(r, s, st, ml, mr, p, md);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic go(input bit st, input bit ml, input bit mr);
        step(1'b1, cur_start, st, ml, mr, cur_pause, cur_mode);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) go(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 0; start = 0; stb = 0; miss_l = 0; miss_r = 0; pause = 0; mode = 0;
        cur_start = 0; cur_pause = 0; cur_mode = 2'd1;

        // reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        chk("rst_lives1", o_lives1, 8'(LV));
        chk("rst_state", 8'(o_state), 8'(ST_IDLE));

        // start -> SERVE with a re-centre pulse
        cur_start = 1; go(1'b0, 1'b0, 1'b0);
        chk("start_brst", 8'(o_ball_rst), 8'd1);
        cur_start = 0;
        go(1'b1, 1'b0, 1'b0); go(1'b0, 1'b0, 1'b0); go(1'b1, 1'b0, 1'b0);
        chk("serve_wait", 8'(o_animate), 8'd0);
        go(1'b1, 1'b0, 1'b0);
        chk("play_anim", 8'(o_animate), 8'd1);

        // right miss: player 1 loses a life, serve goes right
        go(1'b0, 1'b0, 1'b1);
        chk("missr_l1", o_lives1, 8'(LV - 1));
        chk("missr_dir", 8'(o_serve_dir), 8'd1);
        chk("point_anim", 8'(o_animate), 8'd0);
        strobes(PF);
        chk("point_brst", 8'(o_ball_rst), 8'd1);
        chk("point_serve", 8'(o_state), 8'(ST_SERVE));
        strobes(SF);

        // simultaneous misses: only left taken; extra miss in POINT ignored
        go(1'b0, 1'b1, 1'b1);
        chk("both_l2", o_lives2, 8'(LV - 1));
        chk("both_l1", o_lives1, 8'(LV - 1));
        go(1'b0, 1'b0, 1'b1);
        chk("point_miss_ign", o_lives1, 8'(LV - 1));
        strobes(PF);
        strobes(SF);

`ifdef PONG_PAUSE_EN
        cur_pause = 1; go(1'b0, 1'b0, 1'b0);
        chk("pause_anim", 8'(o_animate), 8'd0);
        cur_pause = 0; go(1'b0, 1'b1, 1'b0);
        chk("pause_miss_ign", o_lives2, 8'(LV - 1));
        cur_pause = 1; go(1'b0, 1'b0, 1'b0);
        chk("resume_anim", 8'(o_animate), 8'd1);
        cur_pause = 0; go(1'b0, 1'b0, 1'b0);
`endif

        // mode forced off during PLAY
        cur_mode = 2'd0; go(1'b0, 1'b0, 1'b0);
        chk("mode0_state", 8'(o_state), 8'(ST_IDLE));
        chk("mode0_brst", 8'(o_ball_rst), 8'd1);
        go(1'b0, 1'b0, 1'b0);
        chk("mode0_brst_once", 8'(o_ball_rst), 8'd0);
        chk("mode0_hold_l1", o_lives1, 8'(LV - 1));

        // play a match to the end with start held high
        cur_mode = 2'd2; cur_start = 1; go(1'b0, 1'b0, 1'b0);
        chk("restart_l2", o_lives2, 8'(LV));
        strobes(SF);
        for (int i = 0; i < LV; i++) begin
            go(1'b0, 1'b1, 1'b0);
            if (i < LV - 1) begin strobes(PF); strobes(SF); end
        end
        go(1'b0, 1'b0, 1'b0);
        chk("over_state", 8'(o_state), 8'(ST_OVER));
        chk("over_end", 8'(o_endgame), 8'd1);
        chk("over_win", 8'(o_winner), 8'd1);
        strobes(3);
        chk("over_hold", 8'(o_state), 8'(ST_OVER));
        cur_start = 0; go(1'b0, 1'b0, 1'b0);
        cur_start = 1; go(1'b0, 1'b0, 1'b0);
        chk("rematch_state", 8'(o_state), 8'(ST_SERVE));
        chk("rematch_l2", o_lives2, 8'(LV));
        chk("rematch_win", 8'(o_winner), 8'd0);

        // random play against the model
        for (int n = 0; n < 4000; n++) begin
            bit r, st, ml, mr;
            logic [1:0] md;
            r  = ($urandom_range(0, 299) != 0);
            st = $urandom_range(0, 1) == 1;
            ml = ($urandom_range(0, 7) == 0);
            mr = ($urandom_range(0, 7) == 0);
            md = ($urandom_range(0, 59) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            if ($urandom_range(0, 11) == 0) cur_start = !cur_start;
            cur_pause = ($urandom_range(0, 7) == 0);
            step(r, cur_start, st, ml, mr, cur_pause, md);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
